apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the address.
REQ-002 Parameter: DATA_W, default 8, width of the data.
REQ-003 Parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS cycles without pready (used only with the timeout feature).
REQ-004 Port: pclk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Port: preset  in  1  reset, asynchronous and active-high.
REQ-006 Port: cmd_valid / cmd_ready  in / out  1 each  command handshake.
REQ-007 Port: cmd_write  in  1  1=write, 0=read.
REQ-008 Port: cmd_addr  in  ADDR_W  target address; cmd_wdata  in  DATA_W  write data.
REQ-009 Port: rsp_valid / rsp_ready  out / in  1 each  response handshake.
REQ-010 Port: rsp_rdata  out  DATA_W  read data, 0 for writes.
REQ-011 Port: rsp_err  out  1  slave error or timeout; rsp_timeout  out  1  timeout flag.
REQ-012 Port: psel, penable, pwrite  out  1 each  APB control signals.
REQ-013 Port: paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-014 Port: prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB slave response.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP; encode them as a 2-bit enum.
REQ-016 IDLE behaviour:
- cmd_ready=1, psel=0, penable=0.
- On cmd_valid=1, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, then go to SETUP.
REQ-017 SETUP behaviour: psel=1, penable=0 for exactly one cycle, then go to ACCESS unconditionally.
REQ-018 ACCESS behaviour:
- psel=1, penable=1.
- Remain in ACCESS while pready=0.
- On pready=1, capture prdata (reads only; writes capture 0) and pslverr into rsp_rdata/rsp_err, then go to RESP.
REQ-019 RESP behaviour:
- psel=0, penable=0, rsp_valid=1.
- Hold rsp_rdata, rsp_err and rsp_timeout stable until rsp_ready=1, then go to IDLE.
REQ-020 cmd_ready=0 in every state except IDLE; at most one transfer is outstanding.
REQ-021 paddr, pwrite and pwdata stay stable from SETUP through the final ACCESS cycle, and hold their last value in IDLE and RESP.
REQ-022 Latency: command accepted in cycle N with zero-wait slave gives SETUP in N+1, ACCESS in N+2, rsp_valid in N+3; best throughput is one transfer per 4 cycles.
REQ-023 rsp_valid and rsp_ready both 1 in RESP with cmd_valid already 1: cmd_ready asserts only in the following IDLE cycle, never in the same cycle.
REQ-024 prdata and pslverr are ignored outside ACCESS-with-pready.

Reset
REQ-025 preset=1 asynchronously forces, independent of pclk:
- state=IDLE;
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
- timeout counter=0.
REQ-026 Reset during SETUP, ACCESS or RESP abandons the transfer: no response is produced, and the bus is idle immediately.
REQ-027 After preset falls, the first command is accepted on the first rising edge with cmd_valid=1.

Configuration
REQ-028 Macro APB_MASTER_TIMEOUT_EN defined:
- A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
- When the count reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- pready=1 in the same cycle as the limit takes priority: normal completion.
REQ-029 Macro undefined: ACCESS waits indefinitely, no counter logic exists, and the rsp_timeout port remains but is tied 0.
REQ-030 Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.

Structure
REQ-031 Package apb_pkg holds:
- the state enum apb_master_state_t;
- default ADDR_W and DATA_W localparams;
- the state encodings shared with the APB slave.
REQ-032 One sub-module, apb_wait_timer, instantiated only under APB_MASTER_TIMEOUT_EN.
- Inputs: clear, count enable.
- Output: expired.

Verification
REQ-033 Write, zero-wait slave: cmd_addr=0x10, cmd_wdata=0xA5 -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
REQ-034 Read with 3 wait cycles: pready low for 3 ACCESS cycles, prdata=0x3C -> paddr/psel stable throughout, rsp_rdata=0x3C one cycle after pready.
REQ-035 Slave error: pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles, cmd_valid held -> rsp held constant, cmd_ready=0 until IDLE.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=4): pready never rises -> RESP after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 Reset mid-ACCESS: preset pulse -> psel, penable and rsp_valid all 0 immediately, no response; next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the state encodings used by
// both the APB master bridge and the APB slave.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [1:0] APB_ST_IDLE   = 2'd0;
  localparam logic [1:0] APB_ST_SETUP  = 2'd1;
  localparam logic [1:0] APB_ST_ACCESS = 2'd2;
  localparam logic [1:0] APB_ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = APB_ST_IDLE,
    ST_SETUP  = APB_ST_SETUP,
    ST_ACCESS = APB_ST_ACCESS,
    ST_RESP   = APB_ST_RESP
  } apb_master_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles for the master bridge; used only when
// APB_MASTER_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates at LIMIT so it can never wrap back into a "not expired" value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fires in the wait cycle whose increment reaches the limit.
  assign expired = count_en && (count_d == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge, one transfer outstanding at a time.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS to TIMEOUT_CYCLES wait cycles.
//
// Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
// a response transfers on a rising edge with rsp_valid && rsp_ready. The
// producer holds valid and its payload stable until the transfer happens.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output apb_master_state_t dbg_state
);

  apb_master_state_t state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic rsp_timeout_q, rsp_timeout_d;

  // Clearing during SETUP restarts the count on every entry to ACCESS.
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (pclk),
    .rst     (preset),
    .clear   (state_q == ST_SETUP),
    .count_en((state_q == ST_ACCESS) && !pready),
    .expired (timeout_hit)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A slave completion in the limit cycle wins over the timeout.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b1;
`endif
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // Control outputs decode straight from state so reset idles the bus at once.
  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign rsp_valid = (state_q == ST_RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level expectation queue checked
// every cycle, plus directed literal checks and randomized transfers.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam int EW = 31;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct packed {
    logic          cmd_ready;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
  } exp_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
    int            bp;
    bit            err;
    bit            hold;
  } txn_t;

  // clock / reset
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic              cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err, rsp_timeout;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready, pslverr;
  apb_master_state_t dbg_state;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  exp_t cmp_e, cmp_a;

  // observations for the literal checks
  logic [DW-1:0] obs_rdata;
  logic obs_err, obs_to;
  int acc_cyc, rise_cyc, psel_cyc;
  logic prev_rv = 1'b0;
  logic prev_psel = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic cr, input logic ps, input logic pe,
                                       input logic rv, input logic [DW-1:0] rd,
                                       input logic er, input logic tmo);
    exp_t e;
    e.cmd_ready   = cr;
    e.psel        = ps;
    e.penable     = pe;
    e.pwrite      = m_write;
    e.paddr       = m_addr;
    e.pwdata      = m_wdata;
    e.rsp_valid   = rv;
    e.rsp_rdata   = rd;
    e.rsp_err     = er;
    e.rsp_timeout = tmo;
    return e;
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // compare process: one expected record per cycle
  always @(negedge pclk) begin
    if (!preset && exp_q.size() > 0) begin
      cmp_e = exp_t'(exp_q.pop_front());
      cmp_a.cmd_ready   = cmd_ready;
      cmp_a.psel        = psel;
      cmp_a.penable     = penable;
      cmp_a.pwrite      = pwrite;
      cmp_a.paddr       = paddr;
      cmp_a.pwdata      = pwdata;
      cmp_a.rsp_valid   = rsp_valid;
      cmp_a.rsp_rdata   = rsp_rdata;
      cmp_a.rsp_err     = rsp_err;
      cmp_a.rsp_timeout = rsp_timeout;
      if (!cmp_e.rsp_valid) begin
        cmp_a.rsp_rdata   = '0;
        cmp_a.rsp_err     = 1'b0;
        cmp_a.rsp_timeout = 1'b0;
      end
      chk($sformatf("cycle%0d", cyc), 32'(cmp_a), 32'(cmp_e));
    end
  end

  always @(negedge pclk) begin
    if (!preset) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (rsp_valid && !prev_rv) rise_cyc = cyc;
      if (psel && !prev_psel) psel_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        obs_to    = rsp_timeout;
      end
      prev_rv   = rsp_valid;
      prev_psel = psel;
    end
  end

  // driver tasks
  task automatic rnd_slave();
    pready  = 1'($urandom_range(0, 1));
    prdata  = DW'($urandom);
    pslverr = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    rnd_slave();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    @(posedge pclk); #1;
  endtask

  task automatic do_txn(input txn_t t, input txn_t nt, input bit has_next, input int abort_at);
    bit to_hit;
    int n_acc;
    logic [DW-1:0] e_rd;
    logic e_er, e_to;
    cmd_valid = 1'b1;
    cmd_write = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    rsp_ready = 1'($urandom_range(0, 1));
    rnd_slave();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    @(posedge pclk); #1;
    m_write = t.wr;
    m_addr  = t.addr;
    m_wdata = t.wdata;
    // SETUP: stray commands and slave noise must be ignored
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    rnd_slave();
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    @(posedge pclk); #1;
    to_hit = TIMEOUT_ON && (t.waits >= TO);
    n_acc  = to_hit ? TO : t.waits + 1;
    for (int i = 0; i < n_acc; i++) begin
      if (i == abort_at) begin
        #1 preset = 1'b1;
        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_paddr", paddr, 8'h00);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        @(posedge pclk); #1;
        preset    = 1'b0;
        cmd_valid = 1'b0;
        return;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      rnd_slave();
      if (!to_hit && i == t.waits) begin
        pready  = 1'b1;
        prdata  = t.rdata;
        pslverr = t.err;
      end else begin
        pready = 1'b0;
      end
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      @(posedge pclk); #1;
    end
    e_to = to_hit;
    e_er = to_hit ? 1'b1 : t.err;
    e_rd = (to_hit || t.wr) ? '0 : t.rdata;
    for (int j = 0; j <= t.bp; j++) begin
      rsp_ready = (j == t.bp);
      rnd_slave();
      if (has_next && t.hold) begin
        cmd_valid = 1'b1;
        cmd_write = nt.wr;
        cmd_addr  = nt.addr;
        cmd_wdata = nt.wdata;
      end else begin
        cmd_valid = 1'b0;
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, e_rd, e_er, e_to));
      @(posedge pclk); #1;
    end
    if (!(has_next && t.hold)) cmd_valid = 1'b0;
  endtask

  function automatic txn_t mk_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                                  input logic [7:0] rdata, input int waits, input int bp,
                                  input bit err, input bit hold);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    t.waits = waits; t.bp = bp; t.err = err; t.hold = hold;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, TIMEOUT_ON ? 6 : 5)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
  endfunction

  txn_t t_a, t_b;
  txn_t rq[$];

  initial begin
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    m_write = 1'b0; m_addr = '0; m_wdata = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_psel", psel, 1'b0);
    chk("reset_penable", penable, 1'b0);
    chk("reset_pwrite", pwrite, 1'b0);
    chk("reset_paddr", paddr, 8'h00);
    chk("reset_pwdata", pwdata, 8'h00);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 8'h00);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_timeout", rsp_timeout, 1'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    preset = 1'b0;

    // zero-wait write right after reset release
    t_a = mk_txn(1'b1, 8'h10, 8'hA5, 8'hFF, 0, 0, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("wr_psel_latency", psel_cyc - acc_cyc, 1);
    chk("wr_rsp_latency", rise_cyc - acc_cyc, 3);
    chk("wr_rdata", obs_rdata, 8'h00);
    chk("wr_err", obs_err, 1'b0);

    // read with three wait cycles
    t_a = mk_txn(1'b0, 8'h22, 8'h00, 8'h3C, 3, 0, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("rd_wait_rdata", obs_rdata, 8'h3C);
    chk("rd_wait_latency", rise_cyc - acc_cyc, 6);

    // slave error
    t_a = mk_txn(1'b0, 8'h33, 8'h00, 8'h77, 1, 0, 1'b1, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("slverr_err", obs_err, 1'b1);
    chk("slverr_timeout", obs_to, 1'b0);

    // backpressure with the next command already waiting
    t_a = mk_txn(1'b0, 8'h44, 8'h00, 8'h81, 0, 5, 1'b0, 1'b1);
    t_b = mk_txn(1'b1, 8'h45, 8'h5E, 8'h00, 0, 0, 1'b0, 1'b0);
    do_txn(t_a, t_b, 1'b1, -1);
    chk("bp_rdata", obs_rdata, 8'h81);
    do_txn(t_b, t_b, 1'b0, -1);

`ifdef APB_MASTER_TIMEOUT_EN
    t_a = mk_txn(1'b0, 8'h55, 8'h00, 8'h99, 10, 1, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("to_err", obs_err, 1'b1);
    chk("to_flag", obs_to, 1'b1);
    chk("to_rdata", obs_rdata, 8'h00);
    chk("to_latency", rise_cyc - acc_cyc, 2 + TO);
    t_a = mk_txn(1'b0, 8'h56, 8'h00, 8'h5A, TO - 1, 0, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("to_edge_flag", obs_to, 1'b0);
    chk("to_edge_rdata", obs_rdata, 8'h5A);
`endif

    // reset in the middle of ACCESS, then a clean transfer
    t_a = mk_txn(1'b0, 8'h66, 8'h00, 8'h12, 5, 0, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, 2);
    idle_cycle();
    idle_cycle();
    t_a = mk_txn(1'b0, 8'h67, 8'h00, 8'hC3, 0, 0, 1'b0, 1'b0);
    do_txn(t_a, t_a, 1'b0, -1);
    chk("post_rst_rdata", obs_rdata, 8'hC3);
    chk("post_rst_latency", rise_cyc - acc_cyc, 3);

    // randomized traffic
    for (int k = 0; k < 200; k++) rq.push_back(rnd_txn());
    for (int k = 0; k < rq.size(); k++) begin
      if (k + 1 < rq.size()) do_txn(rq[k], rq[k+1], 1'b1, -1);
      else do_txn(rq[k], rq[k], 1'b0, -1);
      if (!rq[k].hold || k + 1 == rq.size()) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
      end
    end
    idle_cycle();
    idle_cycle();
    @(posedge pclk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

endmodule
